// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with a load/ready handshake,
// per-word bit order, shift-enable stall, bit counter, done pulse and
// overrun flag. ready/busy decode the state register; all other outputs
// are registered.
module piso_serializer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CNT_W    = $clog2(WIDTH + 1),
    parameter logic        IDLE_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             load_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               ser_q, ser_d;
    logic               sv_q, sv_d;
    logic               done_q, done_d;
    logic               lerr_q, lerr_d;

    // Next-state and next-output decode for the IDLE/SHIFT machine.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ser_d   = ser_q;
        sv_d    = 1'b0;
        done_d  = 1'b0;
        lerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ser_d = IDLE_OUT;
                if (load) begin
                    sreg_d  = data_in;
                    mode_d  = lsb_first;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                lerr_d = load;
                if (shift_en) begin
                    if (mode_q) begin
                        ser_d  = sreg_q[0];
                        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                    end else begin
                        ser_d  = sreg_q[WIDTH-1];
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    sv_d  = 1'b1;
                    // Last bit leaves on this edge: return to IDLE so a new
                    // load can be taken in the done cycle itself.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ser_q   <= IDLE_OUT;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ser_q   <= ser_d;
            sv_q    <= sv_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign ser_out   = ser_q;
    assign ser_valid = sv_q;
    assign done      = done_q;
    assign bit_cnt   = cnt_q;
    assign load_err  = lerr_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an 8-bit instance (IDLE_OUT=0) and a 32-bit
// instance (IDLE_OUT=1) checked every cycle against a word/bit-list model,
// plus directed words with literal expected bit streams.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din8 = '0;
    logic [31:0] din32 = '0;
    logic        ld[2];
    logic        lsbf[2];
    logic        sen[2];
    logic        rdy[2], bsy[2], so[2], sv[2], dn[2], lerr[2];
    logic [3:0]  cnt8;
    logic [5:0]  cnt32;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    piso_serializer #(.WIDTH(8), .IDLE_OUT(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .data_in(din8), .load(ld[0]),
        .lsb_first(lsbf[0]), .shift_en(sen[0]), .ready(rdy[0]), .busy(bsy[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .done(dn[0]), .bit_cnt(cnt8),
        .load_err(lerr[0])
    );

    piso_serializer #(.WIDTH(32), .IDLE_OUT(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .data_in(din32), .load(ld[1]),
        .lsb_first(lsbf[1]), .shift_en(sen[1]), .ready(rdy[1]), .busy(bsy[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .done(dn[1]), .bit_cnt(cnt32),
        .load_err(lerr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic int w_of(input int i);
        return (i == 0) ? 8 : 32;
    endfunction

    // ---------------- behavioural model ----------------
    // A word is turned into the list of bits still to be emitted (next bit
    // in position 0); each enabled cycle pops one bit.
    bit          m_act[2];
    logic [63:0] m_rem[2];
    int          m_left[2];
    int          m_cnt[2];
    logic        e_ser[2], e_sv[2], e_done[2], e_lerr[2];

    function automatic logic [63:0] bitrev(input logic [63:0] d, input int w);
        logic [63:0] r = '0;
        for (int k = 0; k < w; k++) r[k] = d[w-1-k];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] = 1'b0; m_rem[i] = '0; m_left[i] = 0; m_cnt[i] = 0;
                e_ser[i] = (i == 1); e_sv[i] = 1'b0; e_done[i] = 1'b0; e_lerr[i] = 1'b0;
            end else begin
                logic [63:0] d;
                d = (i == 0) ? {56'b0, din8} : {32'b0, din32};
                e_lerr[i] = m_act[i] && ld[i];
                e_sv[i]   = 1'b0;
                e_done[i] = 1'b0;
                if (!m_act[i]) begin
                    e_ser[i] = (i == 1);
                    if (ld[i]) begin
                        m_act[i]  = 1'b1;
                        m_left[i] = w_of(i);
                        m_cnt[i]  = 0;
                        m_rem[i]  = lsbf[i] ? d : bitrev(d, w_of(i));
                    end
                end else if (sen[i]) begin
                    e_ser[i] = m_rem[i][0];
                    m_rem[i] = m_rem[i] >> 1;
                    m_left[i]--;
                    m_cnt[i]++;
                    e_sv[i] = 1'b1;
                    if (m_left[i] == 0) begin
                        e_done[i] = 1'b1;
                        m_act[i]  = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ready%0d", i), 64'(rdy[i]), 64'(!m_act[i]));
                chk($sformatf("busy%0d", i), 64'(bsy[i]), 64'(m_act[i]));
                chk($sformatf("ser_out%0d", i), 64'(so[i]), 64'(e_ser[i]));
                chk($sformatf("ser_valid%0d", i), 64'(sv[i]), 64'(e_sv[i]));
                chk($sformatf("done%0d", i), 64'(dn[i]), 64'(e_done[i]));
                chk($sformatf("load_err%0d", i), 64'(lerr[i]), 64'(e_lerr[i]));
                chk($sformatf("bit_cnt%0d", i), (i == 0) ? 64'(cnt8) : 64'(cnt32), 64'(m_cnt[i]));
            end
        end
    end

    // ---------------- stream capture for literal checks ----------------
    logic [63:0] cap[2];
    int ncap[2], ndone[2], nlerr[2], first_v[2], last_v[2], load_cyc[2];
    logic rdy_done[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sv[i]) begin
                if (ncap[i] == 0) first_v[i] = cyc;
                last_v[i] = cyc;
                cap[i] = {cap[i][62:0], so[i]};
                ncap[i]++;
            end
            if (dn[i]) begin
                ndone[i]++;
                rdy_done[i] = rdy[i];
            end
            if (lerr[i]) nlerr[i]++;
        end
    end

    function automatic void clear_cap(input int i);
        cap[i] = '0; ncap[i] = 0; ndone[i] = 0; nlerr[i] = 0;
        first_v[i] = 0; last_v[i] = 0; rdy_done[i] = 1'b0;
    endfunction

    // Called at posedge+1 with the instance idle.
    task automatic do_load(input int i, input logic [31:0] d, input logic l);
        ld[i] = 1'b1; lsbf[i] = l;
        if (i == 0) din8 = d[7:0]; else din32 = d;
        @(posedge clk); #1;
        ld[i] = 1'b0; lsbf[i] = 1'($urandom);
        if (i == 0) din8 = 8'($urandom); else din32 = $urandom;
        load_cyc[i] = cyc;
    endtask

    task automatic wait_done(input int i, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (ndone[i] >= target) return;
            @(posedge clk); #1;
        end
        if (ndone[i] < target) begin
            checks++;
            $display("FAIL wait_done%0d: got %0d done pulses expected %0d within %0d cycles", i, ndone[i], target, budget);
        end
    endtask

    task automatic wait_bits(input int i, input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (ncap[i] >= n) return;
            @(posedge clk); #1;
        end
        if (ncap[i] < n) begin
            checks++;
            $display("FAIL wait_bits%0d: got %0d bits expected %0d within %0d cycles", i, ncap[i], n, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ld[i] = 1'b0; lsbf[i] = 1'b0; sen[i] = 1'b0;
            clear_cap(i);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_ready8", 64'(rdy[0]), 64'd1);
        chk("reset_cnt8", 64'(cnt8), 64'd0);
        chk("reset_ser32_idle", 64'(so[1]), 64'd1);

        // MSB-first 0xB4, shift_en already high during the load.
        sen[0] = 1'b1; clear_cap(0);
        do_load(0, 32'hB4, 1'b0);
        wait_done(0, 1, 40);
        chk("msb_stream", cap[0], 64'hB4);
        chk("msb_nbits", 64'(ncap[0]), 64'd8);
        chk("msb_latency", 64'(last_v[0] - load_cyc[0]), 64'd8);
        chk("msb_cnt_hold", 64'(cnt8), 64'd8);

        // LSB-first 0xB4.
        clear_cap(0);
        do_load(0, 32'hB4, 1'b1);
        wait_done(0, 1, 40);
        chk("lsb_stream", cap[0], 64'h2D);
        chk("lsb_ready_at_done", 64'(rdy_done[0]), 64'd1);

        // 0xFF with shift_en pattern 1,0,0,1,...
        clear_cap(0);
        do_load(0, 32'hFF, 1'b0);
        for (int k = 0; k < 100 && ndone[0] == 0; k++) begin
            sen[0] = (k % 4 == 0) || (k % 4 == 3);
            @(posedge clk); #1;
        end
        sen[0] = 1'b1;
        chk("stall_stream", cap[0], 64'hFF);
        chk("stall_nbits", 64'(ncap[0]), 64'd8);
        chk("stall_ndone", 64'(ndone[0]), 64'd1);

        // Overrun: load of 0x00 (LSB-first) while shifting 0xA5.
        clear_cap(0);
        do_load(0, 32'hA5, 1'b0);
        wait_bits(0, 3, 20);
        ld[0] = 1'b1; din8 = 8'h00; lsbf[0] = 1'b1;
        @(posedge clk); #1;
        ld[0] = 1'b0;
        wait_done(0, 1, 40);
        chk("overrun_stream", cap[0], 64'hA5);
        chk("overrun_nlerr", 64'(nlerr[0]), 64'd1);

        // Reset in the middle of 0xC3, then 0x3C.
        clear_cap(0);
        do_load(0, 32'hC3, 1'b0);
        wait_bits(0, 4, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(rdy[0]), 64'd1);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_valid", 64'(sv[0]), 64'd0);
        chk("rst_cnt", 64'(cnt8), 64'd0);
        chk("rst_ser", 64'(so[0]), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_done", 64'(ndone[0]), 64'd0);
        clear_cap(0);
        do_load(0, 32'h3C, 1'b0);
        wait_done(0, 1, 40);
        chk("post_rst_stream", cap[0], 64'h3C);

        // 32-bit back-to-back: second load in the done cycle.
        sen[1] = 1'b1; clear_cap(1);
        do_load(1, 32'h80000001, 1'b0);
        for (int k = 0; k < 60 && !dn[1]; k++) begin
            @(posedge clk); #1;
        end
        do_load(1, 32'h00000001, 1'b0);
        wait_done(1, 2, 60);
        chk("b2b_stream", cap[1], 64'h80000001_00000001);
        chk("b2b_nbits", 64'(ncap[1]), 64'd64);
        chk("b2b_gap", 64'(last_v[1] - first_v[1] + 1 - 64), 64'd1);
        chk("b2b_nlerr", 64'(nlerr[1]), 64'd0);

        // Randomised traffic on both instances.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 2; i++) begin
                ld[i]   = ($urandom_range(0, 3) == 0);
                lsbf[i] = 1'($urandom);
                sen[i]  = ($urandom_range(0, 9) < 7);
            end
            din8  = 8'($urandom);
            din32 = $urandom;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            ld[i] = 1'b0; sen[i] = 1'b1;
        end
        repeat (40) @(posedge clk);
        #1;
        chk("drain_ready8", 64'(rdy[0]), 64'd1);
        chk("drain_ready32", 64'(rdy[1]), 64'd1);
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
